parity_frame_tx: RTL and testbench

PARITY_FRAME_TX -- requirements
Module: parity_frame_tx

---
 rtl/parity_pkg.sv | 29 ++
 rtl/bit_timer.sv | 47 ++++
 rtl/parity_frame_tx.sv | 154 +++++++++++++++
 tb/tb_parity_frame_tx.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : parity_pkg
//  Description : Shared definitions for the parity frame transmitter: frame
//                geometry constants, the transmitter state enumeration and a
//                parity helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package parity_pkg;

  // Payload width and total serial bits per frame (start + data + parity + stop)
  localparam int DATA_BITS  = 4;
  localparam int FRAME_BITS = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  // 1 when the nibble holds an odd number of ones
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bit_timer
//  Description : Bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps;
//                tick is high while the count sits on its last value, marking
//                the final cycle of the current serial bit.
//  Ports       : clk   - system clock
//                n_rst - asynchronous active-low reset
//                clear - hold the count at 0 (used while the line is idle)
//                tick  - last cycle of the bit period
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  output logic tick
);

  // A one-cycle bit period still needs a 1-bit counter to stay legal
  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/parity_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : parity_frame_tx
//  Description : Serialises a 4-bit nibble with its upstream parity bit into
//                a 7-bit frame: start(0), data LSB first, parity, stop(1).
//                Each bit lasts CLKS_PER_BIT cycles. A mismatch between the
//                supplied parity and the recomputed one raises a sticky error
//                flag; the supplied parity is still transmitted unchanged.
//  Ports       : clk        - system clock, rising edge
//                n_rst      - asynchronous active-low reset
//                data       - nibble to send
//                par_in     - upstream parity of data (1 = odd ones)
//                valid      - data/par_in presented
//                ready      - accepting a nibble this cycle (IDLE only)
//                tx         - serial line, idle high
//                frame_done - one-cycle pulse on the first cycle back in IDLE
//                par_err    - sticky parity mismatch flag
//  Revision    : 1.0 - initial release
// ============================================================================
module parity_frame_tx
  import parity_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 par_in,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 frame_done,
  output logic                 par_err
);

  localparam logic [1:0] LAST_IDX = 2'(DATA_BITS - 1);

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] data_q,  data_d;
  logic                 par_q,   par_d;
  logic [1:0]           idx_q,   idx_d;
  logic                 err_q,   err_d;
  logic                 tx_q,    tx_d;
  logic                 ready_q, ready_d;
  logic                 done_q,  done_d;

  logic tick;
  logic timer_clear;

  // Timer is held at zero while idle so the start bit gets a full period
  // beginning the cycle after the accepting edge.
  assign timer_clear = (state_q == IDLE);

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (timer_clear),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    par_d   = par_q;
    idx_d   = idx_q;
    err_d   = err_q;
    done_d  = 1'b0;
    tx_d    = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (valid) begin
          state_d = START;
          data_d  = data;
          par_d   = par_in;
          idx_d   = '0;
          if (par_in != calc_parity(data)) begin
            err_d = 1'b1;
          end
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == LAST_IDX) begin
            state_d = PARITY;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so that every port is a flop
    // reflecting the state actually entered on this edge.
    ready_d = (state_d == IDLE);

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[idx_d];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      par_q   <= 1'b0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      par_q   <= par_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign ready      = ready_q;
  assign tx         = tx_q;
  assign frame_done = done_q;
  assign par_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parity_frame_tx
//  Description : Self-checking bench. Two instances (CLKS_PER_BIT = 4 and 1)
//                are driven with directed and random nibbles. A reference
//                model at each rising edge decides acceptance and queues the
//                expected frame; per-instance monitors on the falling edge
//                record the line and check each completed frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_frame_tx;

  localparam int NU = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NU-1:0] n_rst_s;
  logic [NU-1:0] valid_s;
  logic [NU-1:0] par_s;
  logic [3:0]    data_s [NU];
  wire  [NU-1:0] ready_w;
  wire  [NU-1:0] tx_w;
  wire  [NU-1:0] done_w;
  wire  [NU-1:0] err_w;

  parity_frame_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .n_rst(n_rst_s[0]), .data(data_s[0]), .par_in(par_s[0]),
    .valid(valid_s[0]), .ready(ready_w[0]), .tx(tx_w[0]),
    .frame_done(done_w[0]), .par_err(err_w[0])
  );

  parity_frame_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .n_rst(n_rst_s[1]), .data(data_s[1]), .par_in(par_s[1]),
    .valid(valid_s[1]), .ready(ready_w[1]), .tx(tx_w[1]),
    .frame_done(done_w[1]), .par_err(err_w[1])
  );

  function automatic int cpb(input int u);
    return (u == 0) ? 4 : 1;
  endfunction

  typedef struct {
    logic [6:0] bits;  // line value per bit slot, slot 0 sent first
    int         acc;   // index of the accepting rising edge
    logic       err;   // expected sticky error after this accept
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int   edge_n;
  int   free_edge [NU];
  logic err_m     [NU];
  int   acc_cnt   [NU];
  int   last_acc  [NU];
  logic txh       [NU][0:8191];
  int   tests;
  int   fails;

  task automatic chk(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (unit %0d, edge %0d): got %0d, expected %0d", name, u, edge_n, act, exp);
    end
  endtask

  // Reference model: a nibble is taken on an edge where valid is high and
  // the previous frame (7 bit periods plus the done cycle) has finished.
  always @(posedge clk) begin : model
    exp_t e;
    for (int u = 0; u < NU; u++) begin
      if (!n_rst_s[u]) begin
        free_edge[u] = 0;
        err_m[u]     = 1'b0;
        if (u == 0) q0.delete(); else q1.delete();
      end else if (valid_s[u] && edge_n >= free_edge[u]) begin
        if (int'(par_s[u]) != ($countones(data_s[u]) % 2)) err_m[u] = 1'b1;
        e.bits = {1'b1, par_s[u], data_s[u], 1'b0};
        e.acc  = edge_n;
        e.err  = err_m[u];
        if (u == 0) q0.push_back(e); else q1.push_back(e);
        free_edge[u] = edge_n + 7 * cpb(u) + 1;
        last_acc[u]  = edge_n;
        acc_cnt[u]++;
      end
    end
    edge_n++;
  end

  task automatic monitor_unit(input int u);
    exp_t e;
    int   c;
    int   n;
    logic got;
    c = cpb(u);
    if (edge_n > 0 && edge_n <= 8192) txh[u][edge_n-1] = tx_w[u];
    if (!n_rst_s[u]) return;
    chk("ready", u, ready_w[u], (edge_n >= free_edge[u]));
    n = (u == 0) ? q0.size() : q1.size();
    if (done_w[u]) begin
      if (n == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected frame_done (unit %0d, edge %0d): got 1, expected 0", u, edge_n);
      end else begin
        e = (u == 0) ? q0.pop_front() : q1.pop_front();
        chk("frame_done timing", u, edge_n, e.acc + 7 * c + 1);
        for (int b = 0; b < 7; b++) begin
          got = e.bits[b];
          for (int t = 0; t < c; t++) begin
            if (txh[u][e.acc + b*c + t] !== e.bits[b]) got = txh[u][e.acc + b*c + t];
          end
          chk($sformatf("tx slot %0d", b), u, got, e.bits[b]);
        end
        chk("par_err at frame end", u, err_w[u], e.err);
      end
    end else if (n != 0) begin
      e = (u == 0) ? q0[0] : q1[0];
      if (edge_n > e.acc + 7 * c + 1) begin
        tests++;
        fails++;
        $display("FAIL missing frame_done (unit %0d, edge %0d): got 0, expected pulse at edge %0d",
                 u, edge_n, e.acc + 7 * c + 1);
        if (u == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end
  endtask

  always @(negedge clk) monitor_unit(0);
  always @(negedge clk) monitor_unit(1);

  task automatic wait_accept(input int u);
    int prev;
    prev = acc_cnt[u];
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (acc_cnt[u] != prev) return;
    end
    tests++;
    fails++;
    $display("FAIL accept timeout (unit %0d): got no accept, expected one within 400 cycles", u);
  endtask

  task automatic send(input int u, input logic [3:0] d, input logic p);
    valid_s[u] = 1'b1;
    data_s[u]  = d;
    par_s[u]   = p;
    wait_accept(u);
  endtask

  // Drop valid and scramble the inputs; the frame must use latched values
  task automatic drop(input int u);
    valid_s[u] = 1'b0;
    data_s[u]  = 4'($urandom);
    par_s[u]   = 1'($urandom);
  endtask

  task automatic wait_idle(input int u);
    int n;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      n = (u == 0) ? q0.size() : q1.size();
      if (edge_n >= free_edge[u] && n == 0) return;
    end
    tests++;
    fails++;
    $display("FAIL idle timeout (unit %0d): got busy, expected idle within 400 cycles", u);
  endtask

  task automatic wait_edge(input int target);
    for (int i = 0; i < 200 && edge_n < target; i++) @(negedge clk);
  endtask

  task automatic random_frames(input int u, input int count);
    for (int i = 0; i < count; i++) begin
      send(u, 4'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) != 0) begin
        drop(u);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    drop(u);
    wait_idle(u);
  endtask

  initial begin
    int k;
    tests   = 0;
    fails   = 0;
    edge_n  = 0;
    n_rst_s = '0;
    valid_s = '0;
    par_s   = '0;
    for (int u = 0; u < NU; u++) begin
      data_s[u]    = '0;
      free_edge[u] = 0;
      err_m[u]     = 1'b0;
      acc_cnt[u]   = 0;
      last_acc[u]  = 0;
    end

    repeat (3) @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      chk("reset tx", u, tx_w[u], 1);
      chk("reset ready", u, ready_w[u], 1);
      chk("reset frame_done", u, done_w[u], 0);
      chk("reset par_err", u, err_w[u], 0);
    end
    #1 n_rst_s = '1;

    // Single frame, good parity
    @(negedge clk);
    send(0, 4'b0010, 1'b1);
    drop(0);
    wait_idle(0);
    chk("par_err after good frame", 0, err_w[0], 0);

    // Parity mismatch: transmitted as given, flag sticks
    send(0, 4'b0011, 1'b1);
    drop(0);
    chk("par_err on accept", 0, err_w[0], 1);
    wait_idle(0);

    // Back-to-back with valid held high
    send(0, 4'b0111, 1'b1);
    send(0, 4'b0000, 1'b0);
    drop(0);
    wait_idle(0);

    // Valid pulsed during the stop bit must be ignored
    send(0, 4'b0101, 1'b0);
    drop(0);
    k = last_acc[0];
    wait_edge(k + 6 * 4 + 2);
    valid_s[0] = 1'b1;
    data_s[0]  = 4'b1111;
    par_s[0]   = 1'b0;
    @(negedge clk);
    chk("busy ready", 0, ready_w[0], 0);
    valid_s[0] = 1'b0;
    wait_idle(0);

    random_frames(0, 15);
    chk("par_err sticky", 0, err_w[0], 1);

    // Reset in the middle of the data bits
    send(0, 4'b0000, 1'b0);
    drop(0);
    wait_edge(last_acc[0] + 2 * 4 + 2);
    #1 n_rst_s[0] = 1'b0;
    #1;
    chk("mid-frame reset tx", 0, tx_w[0], 1);
    chk("mid-frame reset ready", 0, ready_w[0], 1);
    chk("mid-frame reset par_err", 0, err_w[0], 0);
    chk("mid-frame reset frame_done", 0, done_w[0], 0);
    repeat (2) @(negedge clk);
    #1 n_rst_s[0] = 1'b1;
    repeat (40) @(negedge clk);
    send(0, 4'b0110, 1'b0);
    drop(0);
    wait_idle(0);
    chk("par_err after reset", 0, err_w[0], 0);

    // One-cycle bit period
    send(1, 4'b1000, 1'b1);
    drop(1);
    wait_idle(1);
    random_frames(1, 20);

    repeat (5) @(negedge clk);
    chk("leftover frames", 0, q0.size() + q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
